// File: rtl/chunked_subtractor.sv
// chunked_subtractor: multi-cycle Y = A - B, one W-bit chunk per clock LSB first; ports clk, rst, start, A, B in; busy, done, Y, borrow, zero out
module chunked_subtractor #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Y,
  output logic         borrow,
  output logic         zero
);
  localparam int C = N / W;
  localparam int KW = C > 1 ? $clog2(C) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
  logic [KW-1:0] k_q, k_d;
  logic bin_q, bin_d, borrow_q, borrow_d, zero_q, zero_d, busy_q, busy_d, done_q, done_d;
  logic [W:0] diff;
  assign diff = {1'b0, a_q[k_q*W +: W]} - {1'b0, b_q[k_q*W +: W]} - {{W{1'b0}}, bin_q};
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    y_d      = y_q;
    k_d      = k_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d  = RUN;
        a_d      = A;
        b_d      = B;
        y_d      = '0;
        k_d      = '0;
        bin_d    = 1'b0;
        borrow_d = 1'b0;
        zero_d   = 1'b0;
        busy_d   = 1'b1;
      end
      RUN: begin
        y_d[k_q*W +: W] = diff[W-1:0];
        bin_d = diff[W];
        k_d   = k_q + 1'b1;
        if (k_q == KW'(C - 1)) begin
          state_d  = DONE;
          k_d      = '0;
          borrow_d = diff[W];
          zero_d   = (y_d == '0);
          done_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      y_q      <= '0;
      k_q      <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      y_q      <= y_d;
      k_q      <= k_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign Y      = y_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;
endmodule

// File: tb/tb_chunked_subtractor.sv
// tb_chunked_subtractor: table-driven and randomized checks of chunked_subtractor against an arithmetic model
module tb_chunked_subtractor;
  logic clk = 1'b0;
  logic rst, start;
  logic [31:0] A, B, Y;
  logic busy, done, borrow, zero;
  int checks = 0;
  int errors = 0;
  chunked_subtractor #(.N(32), .W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Y(Y), .borrow(borrow), .zero(zero)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        br;
    logic        z;
  } vec_t;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ey, input logic ebr, input logic ez, input bit poke);
    int done_idx, dcnt, bcnt;
    logic [31:0] yd;
    logic brd, zd;
    done_idx = -1;
    dcnt = 0;
    bcnt = 0;
    yd = 'x;
    brd = 1'bx;
    zd = 1'bx;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        if (done_idx < 0) begin
          done_idx = i;
          yd = Y;
          brd = borrow;
          zd = zero;
        end
      end
      if (busy) bcnt++;
      if (i == 0) begin
        start = 1'b0;
        A = $urandom;
        B = $urandom;
      end
      if (poke) start = (i == 1 || i == 4);
    end
    start = 1'b0;
    chk({nm, " done_cycle"}, done_idx, 4);
    chk({nm, " done_pulses"}, dcnt, 1);
    chk({nm, " busy_cycles"}, bcnt, 5);
    chk({nm, " Y"}, yd, ey);
    chk({nm, " borrow"}, {31'b0, brd}, {31'b0, ebr});
    chk({nm, " zero"}, {31'b0, zd}, {31'b0, ez});
    chk({nm, " Y_held"}, Y, ey);
  endtask
  task automatic model_op(input string nm, input logic [31:0] a, input logic [31:0] b, input bit poke);
    logic [31:0] ey;
    ey = a - b;
    do_op(nm, a, b, ey, a < b, ey == 32'h0, poke);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t vecs[6];
    int dl[$];
    int dcnt;
    vecs[0] = '{32'hE59F1020, 32'h00000000, 32'hE59F1020, 1'b0, 1'b0};
    vecs[1] = '{32'hE59F1024, 32'h00000004, 32'hE59F1020, 1'b0, 1'b0};
    vecs[2] = '{32'h00000004, 32'hE59F1024, 32'h1A60EFE0, 1'b1, 1'b0};
    vecs[3] = '{32'h28A44EAF, 32'hA895D275, 32'h800E7C3A, 1'b1, 1'b0};
    vecs[4] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[5] = '{32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b1};
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'h0);
    chk("reset done", {31'b0, done}, 32'h0);
    chk("reset Y", Y, 32'h0);
    chk("reset borrow", {31'b0, borrow}, 32'h0);
    chk("reset zero", {31'b0, zero}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].br, vecs[i].z, 1'b0);
    do_op("poke", 32'h28A44EAF, 32'hA895D275, 32'h800E7C3A, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    A = 32'd5;
    B = 32'd3;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        dl.push_back(i);
        chk("hold Y", Y, 32'd2);
      end
    end
    start = 1'b0;
    chk("hold done_count", dl.size(), 3);
    if (dl.size() == 3) begin
      chk("hold first", dl[0], 4);
      chk("hold gap1", dl[1] - dl[0], 6);
      chk("hold gap2", dl[2] - dl[1], 6);
    end
    repeat (8) @(negedge clk);
    A = 32'hDEADBEEF;
    B = 32'h01234567;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", {31'b0, busy}, 32'h0);
    chk("abort done", {31'b0, done}, 32'h0);
    chk("abort Y", Y, 32'h0);
    chk("abort borrow", {31'b0, borrow}, 32'h0);
    chk("abort zero", {31'b0, zero}, 32'h0);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("abort no_done", dcnt, 0);
    model_op("after_abort", 32'hDEADBEEF, 32'h01234567, 1'b0);
    for (int i = 0; i < 30; i++)
      model_op($sformatf("rand%0d", i), $urandom, (i % 5 == 0) ? 32'($urandom_range(0, 255)) : $urandom, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
